// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART peripheral.
//   Register offsets (addr[3:2]), STAT/CTRL bit positions, FSM state
//   encodings and the minimum effective baud divisor.
package uart_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STAT   = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_RXDATA = 2'd3;

    localparam int STAT_TX_FULL   = 0;
    localparam int STAT_TX_EMPTY  = 1;
    localparam int STAT_TX_BUSY   = 2;
    localparam int STAT_RX_VALID  = 3;
    localparam int STAT_RX_OVR    = 4;
    localparam int STAT_FRAME_ERR = 5;

    localparam int CTRL_TX_EN = 16;
    localparam int CTRL_RX_EN = 17;

    localparam logic [15:0] MIN_DIV = 16'd3;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Divisors below MIN_DIV are clamped so the half-bit RX sample point
    // always lands after the synchroniser latency.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div < MIN_DIV) ? MIN_DIV : div;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous byte FIFO used as the UART transmit queue.
//   clk_i, rst_ni      clock, async active-low reset
//   push_i, wdata_i    enqueue a byte (ignored when full unless popping too)
//   pop_i, rdata_o     dequeue; rdata_o always shows the head entry
//   full_o, empty_o    occupancy flags
//   count_o            number of stored entries (0..DEPTH)
module uart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    assign do_pop  = pop_i && !empty_o;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // the slot wptr points at, so the push can land there.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata_i;
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_periph.sv
// uart_periph: 8N1 UART slave with a TX FIFO and a single-byte RX buffer.
//   clk_i, rst_ni   clock, async active-low reset
//   we_i, be_i      register write strobe and byte enables
//   addr_i          byte address, only [3:2] decoded
//   wdata_i         write data
//   rdata_o         combinational read word for addr_i[3:2]
//   rx_i            asynchronous serial input, idle high
//   tx_o            serial output, idle high
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for tx_en and a queued byte
//   TX_START | driving the start bit (0)
//   TX_DATA  | driving 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (1); may chain into the next frame
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge while rx_en
//   RX_START | waiting half a bit to confirm the start bit
//   RX_DATA  | sampling 8 data bits, one bit time apart
//   RX_STOP  | sampling the stop bit, then delivering the byte
module uart_periph
    import uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd867,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        rx_i,
    output logic        tx_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- register decode ----------------
    logic [1:0] reg_off;
    logic       wr_ctrl, w1c, tx_push;
    logic       rx_pop, clr_ovr, clr_ferr;

    assign reg_off  = addr_i[3:2];
    assign wr_ctrl  = we_i && (reg_off == OFF_CTRL);
    assign w1c      = we_i && (reg_off == OFF_STAT) && be_i[0];
    assign tx_push  = we_i && (reg_off == OFF_TXDATA) && be_i[0];
    assign rx_pop   = w1c && wdata_i[STAT_RX_VALID];
    assign clr_ovr  = w1c && wdata_i[STAT_RX_OVR];
    assign clr_ferr = w1c && wdata_i[STAT_FRAME_ERR];

    logic [15:0] div_q, div_d;
    logic        tx_en_q, tx_en_d;
    logic        rx_en_q, rx_en_d;
    logic [15:0] div_eff;

    assign div_eff = eff_div(div_q);

    always_comb begin
        div_d   = div_q;
        tx_en_d = tx_en_q;
        rx_en_d = rx_en_q;
        if (wr_ctrl) begin
            if (be_i[0]) div_d[7:0]  = wdata_i[7:0];
            if (be_i[1]) div_d[15:8] = wdata_i[15:8];
            if (be_i[2]) begin
                tx_en_d = wdata_i[CTRL_TX_EN];
                rx_en_d = wdata_i[CTRL_RX_EN];
            end
        end
    end

    // ---------------- TX FIFO ----------------
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;

    uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .pop_i   (fifo_pop),
        .wdata_i (wdata_i[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------- TX FSM ----------------
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_q, tx_d;
    logic        tx_go, tx_load, tx_busy;

    assign tx_go = tx_en_q && !fifo_empty;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_load    = 1'b0;
        fifo_pop   = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_load = tx_go;
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = tx_div_q;
                    tx_bit_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = tx_div_q;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_IDLE;
                    tx_load    = tx_go;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Frame start: pop the head byte and latch the divisor for the frame.
        if (tx_load) begin
            tx_state_d = TX_START;
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_rdata;
            tx_div_d   = div_eff;
            tx_cnt_d   = div_eff;
        end
    end

    // Line level is registered from the next state so tx_o is glitch-free
    // and still returns high the instant reset asserts.
    always_comb begin
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_busy = (tx_state_q != TX_IDLE);
    assign tx_o    = tx_q;

    // ---------------- RX FSM ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_sync1_q, rx_sync2_q, rx_prev_q;
    logic        rx_s, rx_fall, rx_deliver;
    logic [16:0] rx_half_sum;
    logic [15:0] rx_half_cnt;

    assign rx_s        = rx_sync2_q;
    assign rx_fall     = rx_prev_q && !rx_s;
    // START lasts (div+1)/2 cycles: the counter terminates at zero.
    assign rx_half_sum = {1'b0, div_eff} + 17'd1;
    assign rx_half_cnt = rx_half_sum[16:1] - 16'd1;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        if (!rx_en_q) begin
            rx_state_d = RX_IDLE;
        end else begin
            unique case (rx_state_q)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_state_d = RX_START;
                        rx_div_d   = div_eff;
                        rx_cnt_d   = rx_half_cnt;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                            rx_cnt_d   = rx_div_q;
                            rx_bit_d   = '0;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_d = {rx_s, rx_shift_q[7:1]};
                        rx_cnt_d   = rx_div_q;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) rx_state_d = RX_IDLE;
                    else                rx_cnt_d   = rx_cnt_q - 16'd1;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    assign rx_deliver = rx_en_q && (rx_state_q == RX_STOP) && (rx_cnt_q == '0);

    // ---------------- RX status / data ----------------
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       frame_err_q, frame_err_d;
    logic [7:0] rx_data_q, rx_data_d;

    always_comb begin
        rx_valid_d  = rx_valid_q;
        rx_ovr_d    = rx_ovr_q;
        frame_err_d = frame_err_q;
        rx_data_d   = rx_data_q;
        if (rx_pop)   rx_valid_d  = 1'b0;
        if (clr_ovr)  rx_ovr_d    = 1'b0;
        if (clr_ferr) frame_err_d = 1'b0;
        if (rx_deliver) begin
            // A pop in the same cycle makes room for the new byte.
            if (!rx_valid_q || rx_pop) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
            if (!rx_s) frame_err_d = 1'b1;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        rdata_o = '0;
        unique case (reg_off)
            OFF_CTRL:   rdata_o = {14'd0, rx_en_q, tx_en_q, div_q};
            OFF_STAT:   rdata_o = {26'd0, frame_err_q, rx_ovr_q, rx_valid_q,
                                   tx_busy, fifo_empty, fifo_full};
            OFF_TXDATA: rdata_o = 32'(fifo_count);
            OFF_RXDATA: rdata_o = {24'd0, rx_data_q};
            default:    rdata_o = '0;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q       <= DEFAULT_DIV;
            tx_en_q     <= 1'b0;
            rx_en_q     <= 1'b0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_div_q    <= '0;
            tx_shift_q  <= '0;
            tx_bit_q    <= '0;
            tx_q        <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_div_q    <= '0;
            rx_shift_q  <= '0;
            rx_bit_q    <= '0;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_data_q   <= '0;
        end else begin
            div_q       <= div_d;
            tx_en_q     <= tx_en_d;
            rx_en_q     <= rx_en_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_shift_q  <= tx_shift_d;
            tx_bit_q    <= tx_bit_d;
            tx_q        <= tx_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_div_q    <= rx_div_d;
            rx_shift_q  <= rx_shift_d;
            rx_bit_q    <= rx_bit_d;
            rx_sync1_q  <= rx_i;
            rx_sync2_q  <= rx_sync1_q;
            rx_prev_q   <= rx_sync2_q;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
            frame_err_q <= frame_err_d;
            rx_data_q   <= rx_data_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:18], be_i[3],
                           rx_half_sum[0]};

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: randomized self-checking bench for uart_periph.
// The reference model tracks registers, the TX byte queue and RX flags
// abstractly; serial waveforms are derived from the bytes with arithmetic.
module tb_uart_periph;

    logic        clk_i   = 1'b0;
    logic        rst_ni  = 1'b0;
    logic        we_i    = 1'b0;
    logic [3:0]  be_i    = 4'h0;
    logic [31:0] addr_i  = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        rx_i    = 1'b1;
    logic        tx_o;

    int n_checks = 0;
    int n_errors = 0;

    uart_periph dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (we_i),
        .be_i    (be_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .rx_i    (rx_i),
        .tx_o    (tx_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    logic [31:0] m_ctrl;
    logic [7:0]  m_fifo[$];
    logic        m_valid, m_ovr, m_ferr;
    logic [7:0]  m_rxdata;

    task automatic model_reset();
        m_ctrl   = 32'h0000_0363;
        m_fifo.delete();
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_ferr   = 1'b0;
        m_rxdata = 8'h00;
    endtask

    function automatic int bit_time();
        int d;
        d = int'(m_ctrl[15:0]);
        return ((d < 3) ? 3 : d) + 1;
    endfunction

    function automatic logic [31:0] exp_stat(input logic busy);
        return {26'd0, m_ferr, m_ovr, m_valid, busy,
                (m_fifo.size() == 0), (m_fifo.size() == 4)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- bus helpers ----------------
    function automatic logic [31:0] mk_addr(input logic [1:0] off);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = off;
        return a;
    endfunction

    task automatic bus_wr(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk_i);
        addr_i  = mk_addr(off);
        wdata_i = data;
        be_i    = be;
        we_i    = 1'b1;
        @(negedge clk_i);
        we_i    = 1'b0;
        be_i    = 4'h0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        addr_i = mk_addr(off);
        #1;
        d = rdata_o;
    endtask

    task automatic ctrl_wr(input logic [31:0] data, input logic [3:0] be);
        bus_wr(2'd0, data, be);
        for (int k = 0; k < 3; k++)
            if (be[k]) m_ctrl[8*k +: 8] = data[8*k +: 8];
        m_ctrl &= 32'h0003_FFFF;
    endtask

    task automatic write_ctrl(input int div, input bit txen, input bit rxen);
        ctrl_wr({14'd0, rxen, txen, 16'(div)}, 4'b0111);
    endtask

    task automatic push(input logic [7:0] b);
        bus_wr(2'd2, {24'hABCDEF, b}, 4'b0001);
        if (m_fifo.size() < 4) m_fifo.push_back(b);
    endtask

    task automatic stat_w1c(input logic [31:0] data, input logic [3:0] be);
        bus_wr(2'd1, data, be);
        if (be[0]) begin
            if (data[3]) m_valid = 1'b0;
            if (data[4]) m_ovr   = 1'b0;
            if (data[5]) m_ferr  = 1'b0;
        end
    endtask

    // ---------------- TX frame checker ----------------
    // Samples tx_o and STAT.tx_busy every cycle of one frame; each bit must
    // hold its value for exactly one bit time.
    task automatic check_frame(input string tag, input bit wait_start);
        int          bt, busy_cnt, w;
        logic [7:0]  byt;
        logic [9:0]  bits;
        logic [31:0] samp, ones;
        bt = bit_time();
        ones = (32'd1 << bt) - 32'd1;
        if (m_fifo.size() == 0) begin
            chk({tag, " model queue"}, 32'd0, 32'd1);
            return;
        end
        byt  = m_fifo.pop_front();
        bits = {1'b1, byt, 1'b0};
        addr_i = mk_addr(2'd1);
        if (wait_start) begin
            w = 0;
            do begin
                @(negedge clk_i);
                w++;
            end while (tx_o !== 1'b0 && w < 400);
            if (tx_o !== 1'b0) begin
                chk({tag, " start timeout"}, {31'd0, tx_o}, 32'd0);
                return;
            end
        end else begin
            @(negedge clk_i);
        end
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            samp = 32'd0;
            for (int j = 0; j < bt; j++) begin
                if (i != 0 || j != 0) @(negedge clk_i);
                samp = (samp << 1) | {31'd0, tx_o};
                busy_cnt += int'(rdata_o[2]);
            end
            chk($sformatf("%s bit%0d", tag, i), samp, bits[i] ? ones : 32'd0);
        end
        chk({tag, " busy cycles"}, busy_cnt, 10 * bt);
    endtask

    // ---------------- RX drivers ----------------
    task automatic send_rx(input logic [7:0] b, input int bt, input bit stop);
        rx_i = 1'b0;
        repeat (bt) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (bt) @(negedge clk_i);
        end
        rx_i = stop;
        repeat (bt) @(negedge clk_i);
        rx_i = 1'b1;
    endtask

    // The stop bit is taken two synchroniser flops plus one edge-detect
    // cycle after the start edge, plus half a bit, plus nine bit times;
    // a pop write is aimed exactly at that cycle when requested.
    task automatic rx_frame(input logic [7:0] b, input bit stop, input bit pop);
        int bt, n;
        bt = bit_time();
        n  = 3 + bt / 2 + 9 * bt;
        if (pop) begin
            fork
                send_rx(b, bt, stop);
                begin
                    repeat (n - 2) @(negedge clk_i);
                    stat_w1c(32'h8, 4'b0001);
                end
            join
        end else begin
            send_rx(b, bt, stop);
        end
        if (!m_valid) begin
            m_rxdata = b;
            m_valid  = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        if (!stop) m_ferr = 1'b1;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] r;
        rd(2'd1, r);
        chk({tag, " STAT"}, r, exp_stat(1'b0));
        rd(2'd3, r);
        chk({tag, " RXDATA"}, r, {24'd0, m_rxdata});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        int          n, w;
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        rd(2'd0, r); chk("rst CTRL", r, 32'h0000_0363);
        rd(2'd1, r); chk("rst STAT", r, 32'h0000_0002);
        rd(2'd2, r); chk("rst TXDATA", r, 32'h0);
        rd(2'd3, r); chk("rst RXDATA", r, 32'h0);
        chk("rst tx_o", {31'd0, tx_o}, 32'd1);

        // single frame, div=9
        write_ctrl(9, 1, 0);
        push(8'hA5);
        check_frame("txA5", 1);

        // fill FIFO with TX disabled, overflow drops the fifth byte
        write_ctrl(9, 0, 0);
        for (int i = 1; i <= 5; i++) push(8'(i));
        rd(2'd2, r); chk("fifo count", r, 32'd4);
        rd(2'd1, r); chk("fifo full STAT", r, exp_stat(1'b0));
        write_ctrl(9, 1, 0);
        check_frame("b2b0", 1);
        for (int i = 1; i < 4; i++) check_frame($sformatf("b2b%0d", i), 0);
        @(negedge clk_i);
        rd(2'd1, r); chk("drained STAT", r, exp_stat(1'b0));

        // partial-byte CTRL write
        ctrl_wr(32'hFFFF_FF05, 4'b0001);
        rd(2'd0, r); chk("ctrl be0", r, m_ctrl);

        // randomized TX, including clamped divisors
        for (int it = 0; it < 4; it++) begin
            write_ctrl((it == 0) ? 1 : int'($urandom_range(0, 12)), 0, 0);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) push(8'($urandom));
            write_ctrl(int'(m_ctrl[15:0]), 1, 0);
            for (int k = 0; k < n; k++) check_frame($sformatf("rtx%0d_%0d", it, k), k == 0);
        end
        write_ctrl(9, 0, 0);

        // basic RX and pop
        write_ctrl(9, 0, 1);
        rx_frame(8'h3C, 1, 0);
        check_rx("rx3C");
        stat_w1c(32'h8, 4'b0001);
        rd(2'd1, r); chk("rx pop", r, exp_stat(1'b0));

        // overrun keeps the old byte
        rx_frame(8'h11, 1, 0);
        rx_frame(8'h22, 1, 0);
        check_rx("ovr");

        // pop exactly on the delivery cycle
        stat_w1c(32'h38, 4'b0001);
        rx_frame(8'h11, 1, 0);
        rx_frame(8'h22, 1, 1);
        check_rx("pop same");

        // W1C without be[0] is ignored
        stat_w1c(32'h38, 4'b1110);
        rd(2'd1, r); chk("w1c no be0", r, exp_stat(1'b0));

        // short glitch on rx_i is rejected
        stat_w1c(32'h38, 4'b0001);
        rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check_rx("glitch");

        // bad stop bit still delivers
        rx_frame(8'h5A, 0, 0);
        check_rx("frame err");

        // randomized RX
        for (int it = 0; it < 5; it++) begin
            write_ctrl(int'($urandom_range(0, 12)), 0, 1);
            if ($urandom_range(0, 1) == 1) stat_w1c(32'h38, 4'b0001);
            rx_frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            check_rx($sformatf("rrx%0d", it));
        end

        // reset in the middle of a frame
        write_ctrl(9, 1, 0);
        push(8'h00);
        w = 0;
        do begin
            @(negedge clk_i);
            w++;
        end while (tx_o !== 1'b0 && w < 400);
        repeat (15) @(negedge clk_i);
        chk("tx low before reset", {31'd0, tx_o}, 32'd0);
        #2 rst_ni = 1'b0;
        #1 chk("tx high on reset", {31'd0, tx_o}, 32'd1);
        model_reset();
        rd(2'd0, r); chk("reset CTRL", r, 32'h0000_0363);
        rd(2'd1, r); chk("reset STAT", r, 32'h0000_0002);
        @(negedge clk_i);
        rst_ni = 1'b1;

        write_ctrl(3, 1, 0);
        push(8'($urandom));
        check_frame("post rst", 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
